// File: rtl/mfp_multi_digit_display_decoder.sv
// Receive-side decoder for a multiplexed eight-digit seven-segment display.
// Rebuilds the 32-bit number and dot vector from the scanned digit lines.
module mfp_multi_digit_display_decoder #(
  parameter int STABLE_FRAMES = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [6:0]  seven_segments,
  input  logic        dot,
  input  logic [7:0]  anodes,
  output logic [31:0] number,
  output logic [7:0]  dots,
  output logic        number_valid,
  output logic        error
);

  localparam logic [3:0] RUN_MAX = 4'd15;
  localparam logic [3:0] RUN_REQ = 4'(STABLE_FRAMES);

  logic [6:0]  s_seg;
  logic        s_dot;
  logic [7:0]  s_an;

  logic [7:0]  an_sel;
  logic        an_idle;
  logic        an_one;
  logic [2:0]  dig;

  logic [3:0]  nib;
  logic        seg_ok;

  logic        smp_ok;
  logic        smp_err;

  logic [31:0] cap;
  logic [31:0] cap_nxt;
  logic [7:0]  cap_dot;
  logic [7:0]  dot_nxt;
  logic [7:0]  seen;
  logic [7:0]  seen_nxt;

  logic        frame_done;
  logic [31:0] cand;
  logic [3:0]  run;
  logic [3:0]  run_nxt;
  logic        accept;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s_seg <= 7'h7F;
      s_dot <= 1'b1;
      s_an  <= 8'hFF;
    end else begin
      s_seg <= seven_segments;
      s_dot <= dot;
      s_an  <= anodes;
    end
  end

  // A digit is selected only when exactly one anode line is pulled low.
  always_comb begin
    an_sel  = ~s_an;
    an_idle = (an_sel == 8'd0);
    an_one  = !an_idle
              && ((an_sel & (an_sel - 8'd1)) == 8'd0);
    dig = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (an_sel[i]) dig = 3'(i);
    end
  end

  always_comb begin
    nib    = 4'h0;
    seg_ok = 1'b1;
    unique case (s_seg)
      7'h40:   nib = 4'h0;
      7'h79:   nib = 4'h1;
      7'h24:   nib = 4'h2;
      7'h30:   nib = 4'h3;
      7'h19:   nib = 4'h4;
      7'h12:   nib = 4'h5;
      7'h02:   nib = 4'h6;
      7'h78:   nib = 4'h7;
      7'h00:   nib = 4'h8;
      7'h18:   nib = 4'h9;
      7'h08:   nib = 4'hA;
      7'h03:   nib = 4'hB;
      7'h46:   nib = 4'hC;
      7'h21:   nib = 4'hD;
      7'h06:   nib = 4'hE;
      7'h0E:   nib = 4'hF;
      default: seg_ok = 1'b0;
    endcase
  end

  // Segments are only judged while a digit is lit; idle lines are ignored.
  always_comb begin
    smp_ok  = an_one && seg_ok;
    smp_err = !an_idle && !smp_ok;
  end

  always_comb begin
    cap_nxt  = cap;
    dot_nxt  = cap_dot;
    seen_nxt = seen;
    cap_nxt[{dig, 2'b00} +: 4] = nib;
    dot_nxt[dig]  = ~s_dot;
    seen_nxt[dig] = 1'b1;
  end

  always_comb begin
    frame_done = smp_ok && (seen_nxt == 8'hFF);
    if (cap_nxt == cand) begin
      run_nxt = (run == RUN_MAX) ? RUN_MAX : run + 4'd1;
    end else begin
      run_nxt = 4'd1;
    end
    accept = frame_done && (run_nxt >= RUN_REQ);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cap     <= 32'd0;
      cap_dot <= 8'd0;
      seen    <= 8'd0;
    end else if (smp_err) begin
      seen <= 8'd0;
    end else if (smp_ok) begin
      cap     <= cap_nxt;
      cap_dot <= dot_nxt;
      seen    <= frame_done ? 8'd0 : seen_nxt;
    end
  end

  // Stability tracks the number only; dot changes never reset the run.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cand <= 32'd0;
      run  <= 4'd0;
    end else if (frame_done) begin
      cand <= cap_nxt;
      run  <= run_nxt;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      number       <= 32'd0;
      dots         <= 8'd0;
      number_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      number_valid <= accept;
      error        <= smp_err;
      if (accept) begin
        number <= cap_nxt;
        dots   <= dot_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mfp_multi_digit_display_decoder.sv
// Bench for mfp_multi_digit_display_decoder: two instances (1 and 3
// stable frames) share stimulus and are checked against a frame model.
module tb_mfp_multi_digit_display_decoder;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic [6:0]  seven_segments = 7'h7F;
  logic        dot = 1'b1;
  logic [7:0]  anodes = 8'hFF;
  logic [31:0] number1, number3;
  logic [7:0]  dots1, dots3;
  logic        nv1, nv3, err1, err3;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  mfp_multi_digit_display_decoder #(.STABLE_FRAMES(1)) dut1 (
    .clock(clock), .resetn(resetn),
    .seven_segments(seven_segments), .dot(dot), .anodes(anodes),
    .number(number1), .dots(dots1),
    .number_valid(nv1), .error(err1)
  );

  mfp_multi_digit_display_decoder #(.STABLE_FRAMES(3)) dut3 (
    .clock(clock), .resetn(resetn),
    .seven_segments(seven_segments), .dot(dot), .anodes(anodes),
    .number(number3), .dots(dots3),
    .number_valid(nv3), .error(err3)
  );

  typedef struct packed {
    logic        v1;
    logic        e1;
    logic [31:0] n1;
    logic [7:0]  d1;
    logic        v3;
    logic        e3;
    logic [31:0] n3;
    logic [7:0]  d3;
  } obs_t;

  obs_t pend_q[$];
  obs_t exp_q[$];
  obs_t obs_q[$];

  logic [6:0] pat [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [3:0]  m_val [8];
  logic        m_dot [8];
  logic [7:0]  m_seen;
  logic [31:0] m_cand [2];
  int          m_run [2];
  logic [31:0] m_num [2];
  logic [7:0]  m_dts [2];
  int          sfv [2] = '{1, 3};

  task automatic model_clear();
    m_seen = 8'd0;
    for (int c = 0; c < 2; c++) begin
      m_cand[c] = 32'd0;
      m_run[c]  = 0;
      m_num[c]  = 32'd0;
      m_dts[c]  = 8'd0;
    end
  endtask

  task automatic model(input logic [7:0] an, input logic [6:0] sg,
                       input logic d, output obs_t e);
    int k, nib;
    logic [31:0] f;
    logic [7:0] fd;
    logic v [2];
    logic er;
    k = -1; nib = -1; er = 1'b0;
    v[0] = 1'b0; v[1] = 1'b0;
    if (an != 8'hFF) begin
      if ($countones(~an) == 1)
        for (int i = 0; i < 8; i++) if (!an[i]) k = i;
      for (int n = 0; n < 16; n++) if (pat[n] == sg) nib = n;
      if (k < 0 || nib < 0) begin
        er = 1'b1;
        m_seen = 8'd0;
      end else begin
        m_val[k] = nib[3:0];
        m_dot[k] = ~d;
        m_seen[k] = 1'b1;
        if (m_seen == 8'hFF) begin
          m_seen = 8'd0;
          f = 32'd0;
          fd = 8'd0;
          for (int i = 0; i < 8; i++) begin
            f = f + (32'(m_val[i]) << (4 * i));
            fd[i] = m_dot[i];
          end
          for (int c = 0; c < 2; c++) begin
            if (f == m_cand[c]) begin
              m_run[c] = (m_run[c] < 15) ? m_run[c] + 1 : 15;
            end else begin
              m_cand[c] = f;
              m_run[c] = 1;
            end
            if (m_run[c] >= sfv[c]) begin
              v[c] = 1'b1;
              m_num[c] = f;
              m_dts[c] = fd;
            end
          end
        end
      end
    end
    e.v1 = v[0]; e.e1 = er; e.n1 = m_num[0]; e.d1 = m_dts[0];
    e.v3 = v[1]; e.e3 = er; e.n3 = m_num[1]; e.d3 = m_dts[1];
  endtask

  // Called at a negedge; observations trail the drive by two edges.
  task automatic step(input logic [7:0] an, input logic [6:0] sg,
                      input logic d);
    obs_t e, o;
    anodes = an;
    seven_segments = sg;
    dot = d;
    model(an, sg, d, e);
    pend_q.push_back(e);
    @(negedge clock);
    if (pend_q.size() == 2) begin
      o = {nv1, err1, number1, dots1, nv3, err3, number3, dots3};
      exp_q.push_back(pend_q.pop_front());
      obs_q.push_back(o);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(8'hFF, 7'($urandom), 1'($urandom));
  endtask

  task automatic dig_step(input int k, input logic [3:0] n,
                          input logic lit);
    logic [7:0] an;
    an = 8'hFF;
    an[k] = 1'b0;
    step(an, pat[n], ~lit);
  endtask

  task automatic scan(input logic [31:0] v, input logic [7:0] dm,
                      input int mode);
    int ord [8];
    int j, t;
    for (int i = 0; i < 8; i++) ord[i] = (mode == 1) ? 7 - i : i;
    if (mode == 2)
      for (int i = 7; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
    for (int i = 0; i < 8; i++) begin
      dig_step(ord[i], v[4*ord[i] +: 4], dm[ord[i]]);
      if (mode == 1) idle(1);
      if (mode == 2 && $urandom_range(3, 0) == 0)
        idle($urandom_range(2, 1));
    end
  endtask

  task automatic do_reset();
    anodes = 8'hFF;
    seven_segments = 7'h7F;
    dot = 1'b1;
    #2 resetn = 1'b0;
    model_clear();
    pend_q.delete();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    do_reset();
    o = {nv1, err1, number1, dots1, nv3, err3, number3, dots3};
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL reset_outputs got %h want 0", o);
    end
    release_reset();
    idle(3);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL reset_idle[%0d] got %h want %h",
                 i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_normal();
    int p [$];
    scan(32'h12345678, 8'h00, 0);
    scan(32'h12345678, 8'h00, 0);
    idle(2);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL normal[%0d] got %h want %h",
                 i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].v1) p.push_back(i);
    end
    tests++;
    if (p.size() != 2 || (p.size() == 2 && p[1] - p[0] != 8)) begin
      fails++;
      $display("FAIL normal_pulses got %0d pulses want 2 spaced 8",
               p.size());
    end
    tests++;
    if (number1 !== 32'h12345678 || dots1 !== 8'h00) begin
      fails++;
      $display("FAIL normal_value got %h/%h want 12345678/00",
               number1, dots1);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_order_dots();
    scan(32'hDEADBEEF, 8'h01, 1);
    idle(2);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL order[%0d] got %h want %h",
                 i, obs_q[i], exp_q[i]);
      end
    end
    tests++;
    if (number1 !== 32'hDEADBEEF || dots1 !== 8'h01) begin
      fails++;
      $display("FAIL order_value got %h/%h want deadbeef/01",
               number1, dots1);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_seg_error();
    int ne, nv;
    ne = 0; nv = 0;
    for (int k = 0; k < 3; k++) dig_step(k, 4'(k + 1), 1'b0);
    step(8'b11110111, 7'h7F, 1'b1);
    idle(2);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL segerr[%0d] got %h want %h",
                 i, obs_q[i], exp_q[i]);
      end
      ne += int'(obs_q[i].e1);
      nv += int'(obs_q[i].v1);
    end
    tests++;
    if (ne != 1 || nv != 0 || number1 !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL segerr_effect got err=%0d val=%0d num=%h want 1 0 deadbeef",
               ne, nv, number1);
    end
    obs_q.delete(); exp_q.delete();
    scan(32'hCAFEF00D, 8'h00, 0);
    idle(2);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL segerr_next[%0d] got %h want %h",
                 i, obs_q[i], exp_q[i]);
      end
    end
    tests++;
    if (number1 !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL segerr_recover got %h want cafef00d", number1);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_anode_error();
    int ne, nv;
    logic [31:0] v;
    ne = 0; nv = 0;
    v = 32'h89ABCDEF;
    dig_step(0, 4'h5, 1'b0);
    dig_step(1, 4'h6, 1'b0);
    step(8'b11111100, pat[5], 1'b1);
    for (int r = 0; r < 2; r++)
      for (int k = 2; k < 8; k++) dig_step(k, v[4*k +: 4], 1'b0);
    idle(2);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL anerr[%0d] got %h want %h",
                 i, obs_q[i], exp_q[i]);
      end
      ne += int'(obs_q[i].e1);
      nv += int'(obs_q[i].v1);
    end
    tests++;
    if (ne != 1 || nv != 0) begin
      fails++;
      $display("FAIL anerr_effect got err=%0d val=%0d want 1 0", ne, nv);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_stability();
    int nv;
    logic [31:0] seq [5];
    nv = 0;
    seq = '{32'h11111111, 32'h11111111, 32'h22222222,
            32'h22222222, 32'h22222222};
    do_reset();
    release_reset();
    for (int f = 0; f < 4; f++) scan(seq[f], 8'h00, 2);
    idle(2);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL stab[%0d] got %h want %h",
                 i, obs_q[i], exp_q[i]);
      end
      nv += int'(obs_q[i].v3);
    end
    tests++;
    if (nv != 0 || number3 !== 32'd0) begin
      fails++;
      $display("FAIL stab_hold got pulses=%0d num=%h want 0 0",
               nv, number3);
    end
    obs_q.delete(); exp_q.delete();
    scan(seq[4], 8'h00, 0);
    idle(2);
    nv = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL stab5[%0d] got %h want %h",
                 i, obs_q[i], exp_q[i]);
      end
      nv += int'(obs_q[i].v3);
    end
    tests++;
    if (nv != 1 || number3 !== 32'h22222222) begin
      fails++;
      $display("FAIL stab_accept got pulses=%0d num=%h want 1 22222222",
               nv, number3);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    obs_t o;
    for (int k = 0; k < 5; k++) dig_step(k, 4'(k + 9), 1'b1);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rstmid_pre[%0d] got %h want %h",
                 i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
    do_reset();
    o = {nv1, err1, number1, dots1, nv3, err3, number3, dots3};
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL rstmid_async got %h want 0", o);
    end
    release_reset();
    scan(32'h00000042, 8'h00, 2);
    idle(2);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rstmid[%0d] got %h want %h",
                 i, obs_q[i], exp_q[i]);
      end
    end
    tests++;
    if (number1 !== 32'h42) begin
      fails++;
      $display("FAIL rstmid_value got %h want 42", number1);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [31:0] pool [2];
    logic [31:0] v;
    logic [6:0] bs;
    logic [7:0] an;
    int r, a, b;
    bit ok;
    pool[0] = $urandom;
    pool[1] = $urandom;
    for (int f = 0; f < 60; f++) begin
      r = $urandom_range(9, 0);
      v = (r < 5) ? pool[r % 2] : $urandom;
      if (r >= 8) begin
        for (int k = 0; k < 3; k++)
          dig_step($urandom_range(7, 0), 4'($urandom), 1'($urandom));
        if (r == 8) begin
          a = $urandom_range(7, 0);
          b = (a + $urandom_range(7, 1)) % 8;
          an = 8'hFF; an[a] = 1'b0; an[b] = 1'b0;
          step(an, pat[$urandom_range(15, 0)], 1'b1);
        end else begin
          do begin
            bs = 7'($urandom);
            ok = 1'b1;
            for (int n = 0; n < 16; n++) if (pat[n] == bs) ok = 1'b0;
          end while (!ok);
          an = 8'hFF; an[$urandom_range(7, 0)] = 1'b0;
          step(an, bs, 1'b1);
        end
      end
      scan(v, 8'($urandom), 2);
    end
    idle(2);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL random[%0d] got %h want %h",
                 i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_normal();
    test_order_dots();
    test_seg_error();
    test_anode_error();
    test_stability();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mfp_multi_digit_display_decoder.md
# mfp_multi_digit_display_decoder

Receive-side counterpart of the multiplexed eight-digit seven-segment display driver. It samples the scanned segment, dot and anode lines and decodes each lit digit's segment pattern back to a hex nibble. Once all eight digits of a scan have been captured, it reassembles the 32-bit number. Uses: on-chip readback and self-check of the display path, and a bench monitor for display-driving software.

## Interface

Parameters:
- STABLE_FRAMES, default 1: number of consecutive identical complete frames required before `number` is updated. Legal range 1..15.

Ports:
- clock  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- seven_segments  in  7  active-low segments, bit0=a, bit1=b … bit6=g.
- dot  in  1  active-low decimal point of the currently selected digit.
- anodes  in  8  active-low digit selects; bit k selects digit k, nibble number[4k+3:4k].
- number  out  32  last accepted reassembled value.
- dots  out  8  active-high lit decimal points of the last accepted frame.
- number_valid  out  1  one-cycle pulse on each accepted frame.
- error  out  1  one-cycle pulse on each rejected sample.

## Operation

- **Input stage.**
  - seven_segments, dot and anodes are registered once (s_seg, s_dot, s_an) before any decode.
  - Reset value of s_an is 8'hFF.
- **Anode classification** of s_an, one result per cycle:
  - all ones: idle, nothing happens.
  - exactly one zero at bit k: digit sample for k.
  - two or more zeros: anode error.
- **Segment decode**, s_seg to nibble:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:18, A:08, B:03, C:46, D:21, E:06, F:0E
  - Any other pattern is a segment error.
- **Valid digit sample k:**
  - cap[k] <= nibble; cap_dot[k] <= ~s_dot; seen[k] <= 1.
  - A digit already captured in the current frame is overwritten with the newer value; seen is unchanged.
  - Scan order is irrelevant.
- **Error (anode or segment):**
  - error pulses.
  - seen is cleared to 0 and the partial frame is discarded.
  - cap, number and the stability state are unchanged.
- **Frame complete:** the cycle in which a valid sample makes seen == 8'hFF, counting the digit being written that cycle.
  - frame value F = cap with the current nibble substituted; same for the dot vector.
  - seen is cleared.
  - Stability check:
    - if F == cand, then run <= min(run+1, 15);
    - else cand <= F, run <= 1.
  - The frame is accepted when the updated run >= STABLE_FRAMES. Then number <= F, dots <= dot vector, and number_valid pulses.
  - Every qualifying frame is accepted, including repeats of the same value.
- **Stability state** (cand, run) compares the 32-bit number only; dots are not compared.
- **Reset values:**
  - outputs: number=0, dots=0, number_valid=0, error=0.
  - internal: seen=0, cap=0, cand=0, run=0, s_an=8'hFF, s_seg=7'h7F, s_dot=1.
- **Reset mid-frame:** all partial capture is lost. The first accepted frame after reset requires eight fresh valid digit samples.

## Timing

- A sample present on the inputs at edge t is registered at t and classified/decoded during t..t+1. cap, seen, number, dots, number_valid and error update at edge t+1.
- Latency from the last digit of a frame to number_valid/number: 2 edges.
- number_valid and error are never asserted in the same cycle. A sample is either valid (possibly completing a frame) or an error.
- No handshake; number holds its value between accepted frames. Consumers sample number in the number_valid cycle or later.
- Input rate: one digit per cycle supported; arbitrary idle cycles between digits allowed. Inputs are assumed synchronous to clock.

## Test plan

- **Normal scan.** STABLE_FRAMES=1. Drive digits 0..7, one per cycle, with the patterns of 0x12345678 and dot high.
  - number_valid pulses 2 edges after digit 7.
  - number=32'h12345678, dots=8'h00.
  - Repeating the scan pulses number_valid every 8 cycles.
- **Order and dots.** Scan digits 7..0 with idle cycles interleaved, value 0xDEADBEEF, dot low on digit 0 only.
  - number=32'hDEADBEEF, dots=8'h01.
- **Segment error.** Pattern 7'h7F on digit 3 mid-frame.
  - error pulses once and no number_valid for that frame; number retains its previous value.
  - The next clean frame of 0xCAFEF00D is accepted.
- **Anode error.** anodes=8'b11111100 for one cycle.
  - error pulses and the frame restarts.
  - Frames with only digits 2..7 after the error produce no number_valid.
- **Stability.** STABLE_FRAMES=3. Send frames A=0x11111111, A, B=0x22222222, B, B.
  - No pulse on the first four frames; pulse on the fifth with number=0x22222222.
  - number stays 0 until then.
- **Reset mid-frame.** Assert resetn low after 5 digits, then release.
  - All outputs are 0 immediately (asynchronous).
  - A subsequent full frame of 0x00000042 gives number_valid with number=0x42.
